// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the PWM audio sample path.
// Contents: PWM_W (level width), PERIOD (counter period), IDLE_LEVEL_DEFAULT
// (midscale level), sched_state_t (scheduler FSM states), pick_level().
package pwm_audio_pkg;

    localparam int unsigned PWM_W  = 11;
    localparam int unsigned PERIOD = 2048;

    localparam logic [PWM_W-1:0] IDLE_LEVEL_DEFAULT = 11'd1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sched_state_t;

    // Selects the idle level when forced, otherwise the sample.
    function automatic logic [PWM_W-1:0] pick_level(
        input logic             force_idle,
        input logic [PWM_W-1:0] sample,
        input logic [PWM_W-1:0] idle_level
    );
        return force_idle ? idle_level : sample;
    endfunction

endpackage

// File: rtl/pwm_sample_scheduler_if.sv
// Sample stream handshake between a producer and the scheduler.
// Signals: s_valid (sample offered), s_data (11-bit unsigned sample),
// s_ready (scheduler can take a sample this cycle).
// Modports: master drives valid/data, slave drives ready.
interface pwm_sample_scheduler_if;
    import pwm_audio_pkg::*;

    logic             s_valid;
    logic [PWM_W-1:0] s_data;
    logic             s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/pwm_sample_fifo.sv
// Small synchronous sample FIFO with show-ahead head output.
// Ports: clk, rst_n (async active-low), push/pop requests, flush (clears all
// entries, wins over push and pop), din, dout (current head), count
// (occupancy 0..DEPTH), full, empty.
module pwm_sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PWM_W = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [PWM_W-1:0]             din,
    output logic [PWM_W-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PWM_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointer advance that wraps at DEPTH, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// Buffers incoming samples and hands one to the PWM generator per PWM period.
// Ports: clk, rst_n (async assert, synchronised release), enable (playback
// request), mute (force idle level, popping continues), s_if (sample
// handshake, slave side), pwm_level (level held for a whole period),
// period_tick (high while the period counter is 0), underflow (one-cycle
// pulse on an empty pop in RUN), fifo_count (occupancy).
module pwm_sample_scheduler
    import pwm_audio_pkg::*;
#(
    parameter int unsigned      DEPTH       = 4,
    parameter int unsigned      PRIME_LEVEL = 2,
    parameter logic [PWM_W-1:0] IDLE_LEVEL  = IDLE_LEVEL_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mute,
    pwm_sample_scheduler_if.slave s_if,
    output logic [PWM_W-1:0]     pwm_level,
    output logic                 period_tick,
    output logic                 underflow,
    output logic [2:0]           fifo_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    logic [PWM_W-1:0] r_cnt;
    logic             r_cnt_live;
    logic             r_tick;
    logic             w_boundary;

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [PWM_W-1:0] r_level;
    logic [PWM_W-1:0] w_level_next;
    logic             r_underflow;
    logic             w_underflow_next;
    logic             r_s_ready;

    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [PWM_W-1:0] w_head;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_full;
    logic             w_empty;

    // Reset asserts immediately, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Period counter. The first edge out of reset reloads 0 and raises the
    // tick, so the PWM ramp and this counter start their first period together.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt      <= '0;
            r_cnt_live <= 1'b0;
            r_tick     <= 1'b0;
        end else if (!r_cnt_live) begin
            r_cnt      <= '0;
            r_cnt_live <= 1'b1;
            r_tick     <= 1'b1;
        end else begin
            r_cnt      <= r_cnt + PWM_W'(1);
            r_tick     <= (r_cnt == PWM_W'(PERIOD - 1));
        end
    end

    // Boundary = the edge on which cnt wraps from its last value to 0.
    assign w_boundary = r_cnt_live && (r_cnt == PWM_W'(PERIOD - 1));

    // Accept only against the registered ready, so a full FIFO refuses a push
    // even when a pop happens on the same edge.
    assign w_push = s_if.s_valid && r_s_ready && !w_full;

    pwm_sample_fifo #(
        .DEPTH (DEPTH),
        .PWM_W (PWM_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (w_rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (s_if.s_data),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next state, FIFO control and next output level.
    always_comb begin
        w_state_next     = r_state;
        w_pop            = 1'b0;
        w_flush          = 1'b0;
        w_level_next     = r_level;
        w_underflow_next = 1'b0;
        case (r_state)
            IDLE: begin
                w_flush      = 1'b1;
                w_level_next = IDLE_LEVEL;
                if (enable) begin
                    w_state_next = PRIME;
                end
            end
            PRIME: begin
                if (w_boundary) begin
                    if (!enable) begin
                        w_state_next = IDLE;
                        w_flush      = 1'b1;
                        w_level_next = IDLE_LEVEL;
                    end else if (w_count >= CNT_W'(PRIME_LEVEL)) begin
                        w_state_next = RUN;
                        w_pop        = !w_empty;
                        w_level_next = pick_level(mute || w_empty, w_head, IDLE_LEVEL);
                    end
                end
            end
            RUN: begin
                if (w_boundary) begin
                    if (!enable) begin
                        w_state_next = IDLE;
                        w_flush      = 1'b1;
                        w_level_next = IDLE_LEVEL;
                    end else if (w_empty) begin
                        w_level_next     = IDLE_LEVEL;
                        w_underflow_next = 1'b1;
                    end else begin
                        w_pop        = 1'b1;
                        w_level_next = pick_level(mute, w_head, IDLE_LEVEL);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_flush      = 1'b1;
                w_level_next = IDLE_LEVEL;
            end
        endcase
    end

    // Occupancy after this edge, used to register s_ready.
    always_comb begin
        w_count_next = w_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = w_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = w_count - CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= IDLE;
            r_level     <= IDLE_LEVEL;
            r_underflow <= 1'b0;
            r_s_ready   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_level     <= w_level_next;
            r_underflow <= w_underflow_next;
            r_s_ready   <= (w_state_next != IDLE) && (w_count_next < CNT_W'(DEPTH));
        end
    end

    assign s_if.s_ready = r_s_ready;
    assign pwm_level    = r_level;
    assign period_tick  = r_tick;
    assign underflow    = r_underflow;
    assign fifo_count   = 3'(w_count);

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Self-checking bench for pwm_sample_scheduler: directed scenarios plus a
// randomized stretch, every cycle compared against a queue-based reference.
module tb_pwm_sample_scheduler;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned PRIME_LEVEL = 2;
    localparam int unsigned PERIOD      = 2048;
    localparam logic [10:0] IDLE_LVL    = 11'd1024;
    localparam int          M_IDLE      = 0;
    localparam int          M_PRIME     = 1;
    localparam int          M_RUN       = 2;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        mute;
    logic [10:0] pwm_level;
    logic        period_tick;
    logic        underflow;
    logic [2:0]  fifo_count;

    pwm_sample_scheduler_if s_if ();

    pwm_sample_scheduler #(
        .DEPTH       (DEPTH),
        .PRIME_LEVEL (PRIME_LEVEL),
        .IDLE_LEVEL  (IDLE_LVL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mute        (mute),
        .s_if        (s_if),
        .pwm_level   (pwm_level),
        .period_tick (period_tick),
        .underflow   (underflow),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset release, playback mode, sample queue.
    int          m_edges;
    int          m_mode;
    logic [10:0] m_level;
    bit          m_uf;
    logic [10:0] m_q[$];

    task automatic summary_and_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
        if (errors >= 40) summary_and_finish();
    endtask

    function automatic int model_cnt();
        return (m_edges < 3) ? 0 : (m_edges - 3) % PERIOD;
    endfunction

    function automatic bit model_ready();
        return (m_mode != M_IDLE) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_mode  = M_IDLE;
        m_q.delete();
        m_level = IDLE_LVL;
        m_uf    = 1'b0;
    endtask

    // Advance the reference by one rising edge using the inputs as driven.
    task automatic model_edge();
        bit          push;
        bit          bnd;
        logic [10:0] v;
        if (!rst_n) return;
        push = s_if.s_valid && model_ready();
        m_uf = 1'b0;
        if (m_edges >= 2) begin
            bnd = (m_edges >= 3) && (((m_edges - 3) % PERIOD) == PERIOD - 1);
            if (m_mode == M_IDLE) begin
                m_q.delete();
                m_level = IDLE_LVL;
                if (enable) m_mode = M_PRIME;
            end else if (bnd && !enable) begin
                m_mode  = M_IDLE;
                m_q.delete();
                push    = 1'b0;
                m_level = IDLE_LVL;
            end else if (bnd && m_mode == M_PRIME) begin
                if (m_q.size() >= PRIME_LEVEL) begin
                    m_mode = M_RUN;
                    if (m_q.size() > 0) begin
                        v       = m_q.pop_front();
                        m_level = mute ? IDLE_LVL : v;
                    end else begin
                        m_level = IDLE_LVL;
                    end
                end
            end else if (bnd && m_mode == M_RUN) begin
                if (m_q.size() == 0) begin
                    m_level = IDLE_LVL;
                    m_uf    = 1'b1;
                end else begin
                    v       = m_q.pop_front();
                    m_level = mute ? IDLE_LVL : v;
                end
            end
            if (push) m_q.push_back(s_if.s_data);
        end
        m_edges++;
    endtask

    task automatic check_all();
        chk("pwm_level",   32'(pwm_level),    32'(m_level));
        chk("period_tick", 32'(period_tick),  32'((m_edges >= 3) && (model_cnt() == 0)));
        chk("underflow",   32'(underflow),    32'(m_uf));
        chk("fifo_count",  32'(fifo_count),   32'(m_q.size()));
        chk("s_ready",     32'(s_if.s_ready), 32'(model_ready()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_until_cnt(input int c);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (model_cnt() != c && n < 2 * PERIOD + 8);
        chk("wait_cnt", 32'(model_cnt()), 32'(c));
    endtask

    task automatic push_sample(input logic [10:0] v);
        bit acc;
        s_if.s_valid = 1'b1;
        s_if.s_data  = v;
        for (int n = 0; n < 16; n++) begin
            acc = model_ready();
            step();
            if (acc) break;
        end
        s_if.s_valid = 1'b0;
    endtask

    logic [10:0] lvl_hold;
    int          rate;

    initial begin
        rst_n        = 1'b1;
        enable       = 1'b0;
        mute         = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        model_reset();
        #1 rst_n = 1'b0;

        // Reset values.
        repeat (3) step();
        chk("rst_level", 32'(pwm_level), 32'd1024);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(s_if.s_ready), 32'd0);
        chk("rst_tick",  32'(period_tick), 32'd0);
        chk("rst_uf",    32'(underflow), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("restart_tick", 32'(period_tick), 32'd1);

        // Two samples play out on consecutive boundaries.
        enable = 1'b1;
        step();
        push_sample(11'd100);
        push_sample(11'd200);
        run_until_cnt(0);
        chk("req032_lvl100_c0", 32'(pwm_level), 32'd100);
        run_until_cnt(1024);
        chk("req032_lvl100_c1024", 32'(pwm_level), 32'd100);
        run_until_cnt(2047);
        chk("req032_lvl100_c2047", 32'(pwm_level), 32'd100);
        step();
        chk("req032_lvl200", 32'(pwm_level), 32'd200);

        // Single entry, then an empty pop.
        push_sample(11'd300);
        run_until_cnt(0);
        chk("req033_lvl300", 32'(pwm_level), 32'd300);
        run_until_cnt(2047);
        step();
        chk("req033_lvl_idle", 32'(pwm_level), 32'd1024);
        chk("req033_uf_high", 32'(underflow), 32'd1);
        step();
        chk("req033_uf_low", 32'(underflow), 32'd0);

        // Fill to full with valid held; push on the pop edge is refused.
        s_if.s_valid = 1'b1;
        s_if.s_data  = 11'd500;
        for (int n = 0; n < 10; n++) begin
            step();
            if (m_q.size() == DEPTH) break;
        end
        chk("req034_full_count", 32'(fifo_count), 32'd4);
        chk("req034_full_ready", 32'(s_if.s_ready), 32'd0);
        run_until_cnt(0);
        chk("req034_pop_count", 32'(fifo_count), 32'd3);
        chk("req034_pop_level", 32'(pwm_level), 32'd500);
        step();
        chk("req034_refill_count", 32'(fifo_count), 32'd4);
        s_if.s_valid = 1'b0;

        // Muted boundary still pops.
        mute = 1'b1;
        run_until_cnt(0);
        chk("req035_mute_level", 32'(pwm_level), 32'd1024);
        chk("req035_mute_count", 32'(fifo_count), 32'd3);
        mute = 1'b0;

        // Randomized traffic and mute at varying push rates.
        for (int p = 0; p < 6; p++) begin
            rate = int'($urandom_range(0, 3));
            mute = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < PERIOD; k++) begin
                s_if.s_valid = ($urandom_range(0, PERIOD - 1) < rate);
                s_if.s_data  = 11'($urandom_range(0, 2047));
                if ($urandom_range(0, 999) == 0) mute = ~mute;
                step();
            end
        end
        s_if.s_valid = 1'b0;
        mute         = 1'b0;

        // Disable mid-period: level holds until the wrap, then idle.
        run_until_cnt(700);
        enable   = 1'b0;
        lvl_hold = m_level;
        run_until_cnt(2047);
        chk("req036_hold", 32'(pwm_level), 32'(lvl_hold));
        step();
        chk("req036_level", 32'(pwm_level), 32'd1024);
        chk("req036_count", 32'(fifo_count), 32'd0);

        // Short enable pulse returns to idle at the boundary.
        run_until_cnt(100);
        enable = 1'b1;
        step();
        push_sample(11'd77);
        enable = 1'b0;
        chk("req025_prime_count", 32'(fifo_count), 32'd1);
        run_until_cnt(0);
        chk("req025_count", 32'(fifo_count), 32'd0);
        chk("req025_ready", 32'(s_if.s_ready), 32'd0);

        // Reset mid-period with entries queued.
        enable = 1'b1;
        step();
        for (int n = 0; n < 4; n++) push_sample(11'($urandom_range(0, 2047)));
        run_until_cnt(0);
        chk("req037_run_count", 32'(fifo_count), 32'd3);
        run_until_cnt(1500);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("req037_count", 32'(fifo_count), 32'd0);
        chk("req037_level", 32'(pwm_level), 32'd1024);
        chk("req037_ready", 32'(s_if.s_ready), 32'd0);
        chk("req037_uf",    32'(underflow), 32'd0);
        chk("req037_tick0", 32'(period_tick), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("req037_tick", 32'(period_tick), 32'd1);
        repeat (8) step();

        summary_and_finish();
    end

endmodule
